enable_reg_bank: RTL and testbench

Parametrised multi-channel register bank with a divided capture strobe and a counter-generated periodic clear, all in a single clock domain. Each channel selects full-rate or divided-rate capture and can opt in or out of the periodic clear. Divided clocks and derived asynchronous resets are replaced by clock enables and synchronous clears. It serves as the scan-friendly, DFT-clean benchmark block alongside the derived-clock/derived-reset test designs.

---
 rtl/enable_reg_bank_pkg.sv | 14 +
 rtl/mod_counter.sv | 30 +++
 rtl/enable_reg_bank.sv | 62 ++++++
 tb/tb_enable_reg_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/enable_reg_bank_pkg.sv
// rtl/enable_reg_bank_pkg.sv - shared defaults and counter sizing for enable_reg_bank
package enable_reg_bank_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_CHANNELS   = 3;
    localparam int DEF_DIV        = 2;
    localparam int DEF_CLR_PERIOD = 16;

    // Never narrower than one bit, so a modulo-1 counter still has a register.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - free-running modulo-N counter with terminal-count decode
module mod_counter
    import enable_reg_bank_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tc
);

    localparam int            W    = cnt_width(N);
    localparam logic [W-1:0]  LAST = W'(N - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decoded from the register only; for N=1 this is constantly high.
    assign tc = (cnt == LAST);

endmodule

// File: rtl/enable_reg_bank.sv
// rtl/enable_reg_bank.sv - multi-channel register bank with divided capture enable and periodic clear
module enable_reg_bank
    import enable_reg_bank_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int DIV        = DEF_DIV,
    parameter int CLR_PERIOD = DEF_CLR_PERIOD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       ch_div,
    input  logic [CHANNELS-1:0]       ch_clr,
    input  logic                      hold,
    input  logic                      clr_en,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic                      ce_o,
    output logic                      clr_o
);

    logic ce;
    logic clr_tc;
    logic clr;

    mod_counter #(.N(DIV)) u_div_cnt (
        .clk (clk),
        .rst (rst),
        .tc  (ce)
    );

    mod_counter #(.N(CLR_PERIOD)) u_clr_cnt (
        .clk (clk),
        .rst (rst),
        .tc  (clr_tc)
    );

    assign clr   = clr_en & clr_tc;
    assign ce_o  = ce;
    assign clr_o = clr;

    // Clear outranks hold, hold outranks capture.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             cap;
        logic [WIDTH-1:0] r;

        assign cap = ch_div[i] ? ce : 1'b1;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r <= '0;
            end else if (clr && ch_clr[i]) begin
                r <= '0;
            end else if (!hold && cap) begin
                r <= d[i*WIDTH +: WIDTH];
            end
        end

        assign q[i*WIDTH +: WIDTH] = r;
    end

endmodule

// File: tb/tb_enable_reg_bank.sv
// tb/tb_enable_reg_bank.sv - self-checking bench for enable_reg_bank, default and swept parameters
module tb_enable_reg_bank;

    logic        clk = 1'b0;
    logic        rst;

    logic [11:0] da;
    logic [2:0]  cha_div, cha_clr;
    logic        hold_a, clr_en_a;
    logic [11:0] qa;
    logic        ce_a, clr_a;

    logic [39:0] db;
    logic [4:0]  chb_div, chb_clr;
    logic        hold_b, clr_en_b;
    logic [39:0] qb;
    logic        ce_b, clr_b;

    int          checks = 0;
    int          passes = 0;
    int          k = 0;
    logic [39:0] mqa, mqb;

    always #5 clk = ~clk;

    enable_reg_bank dut_a (
        .clk    (clk),
        .rst    (rst),
        .d      (da),
        .ch_div (cha_div),
        .ch_clr (cha_clr),
        .hold   (hold_a),
        .clr_en (clr_en_a),
        .q      (qa),
        .ce_o   (ce_a),
        .clr_o  (clr_a)
    );

    enable_reg_bank #(.WIDTH(8), .CHANNELS(5), .DIV(3), .CLR_PERIOD(7)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .d      (db),
        .ch_div (chb_div),
        .ch_clr (chb_clr),
        .hold   (hold_b),
        .clr_en (clr_en_b),
        .q      (qb),
        .ce_o   (ce_b),
        .clr_o  (clr_b)
    );

    // k is the number of edges with rst high since the last reset edge.
    function automatic logic exp_ce(input int n, input int div);
        return (n % div) == (div - 1);
    endfunction

    function automatic logic exp_clr(input int n, input int per, input logic en);
        return en && ((n % per) == (per - 1));
    endfunction

    function automatic logic [39:0] model_next(input logic [39:0] q, input logic [39:0] d,
                                               input int w, input int nch,
                                               input logic [4:0] cdiv, input logic [4:0] cclr,
                                               input logic hold, input logic ce, input logic clr);
        logic [39:0] r;
        r = q;
        for (int c = 0; c < nch; c++) begin
            logic zero, load;
            zero = clr && cclr[c];
            load = !zero && !hold && (cdiv[c] ? ce : 1'b1);
            for (int b = 0; b < w; b++) begin
                if (zero)      r[c*w+b] = 1'b0;
                else if (load) r[c*w+b] = d[c*w+b];
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h (k=%0d)", name, got, exp, k);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) begin
            mqa = '0;
            mqb = '0;
            k   = 0;
        end else begin
            mqa = model_next(mqa, {28'b0, da}, 4, 3, {2'b0, cha_div}, {2'b0, cha_clr},
                             hold_a, exp_ce(k, 2), exp_clr(k, 16, clr_en_a));
            mqb = model_next(mqb, db, 8, 5, chb_div, chb_clr,
                             hold_b, exp_ce(k, 3), exp_clr(k, 7, clr_en_b));
            k++;
        end
        @(negedge clk);
        check("q_a",   {28'b0, qa},    mqa);
        check("ce_a",  {39'b0, ce_a},  {39'b0, exp_ce(k, 2)});
        check("clr_a", {39'b0, clr_a}, {39'b0, exp_clr(k, 16, clr_en_a)});
        check("q_b",   qb,             mqb);
        check("ce_b",  {39'b0, ce_b},  {39'b0, exp_ce(k, 3)});
        check("clr_b", {39'b0, clr_b}, {39'b0, exp_clr(k, 7, clr_en_b)});
    endtask

    task automatic rand_b(input bit full);
        db       = 40'({$urandom(), $urandom()});
        chb_div  = 5'($urandom());
        chb_clr  = 5'($urandom());
        hold_b   = full ? ($urandom_range(0, 3) == 0) : 1'b0;
        clr_en_b = full ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            rand_b(1'b0);
            cycle();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; da = '1; cha_div = '0; cha_clr = '0; hold_a = 1'b0; clr_en_a = 1'b0;
        mqa = '0; mqb = '0;
        rand_b(1'b0);

        // Reset with data all ones.
        do_reset(3);
        check("reset_q",   {28'b0, qa},    40'h0);
        check("reset_ce",  {39'b0, ce_a},  40'h0);
        check("reset_clr", {39'b0, clr_a}, 40'h0);

        // Ramp: channel 1 divided, others full rate.
        cha_div = 3'b010;
        for (int i = 0; i < 7; i++) begin
            da = {3{4'(k)}};
            rand_b(1'b0);
            cycle();
        end
        check("ramp_q", {28'b0, qa}, 40'h656);

        // Periodic clear on channels 0 and 2.
        do_reset(1);
        cha_div = 3'b000; cha_clr = 3'b101; clr_en_a = 1'b1; da = 12'hAAA;
        for (int i = 0; i < 16; i++) begin
            rand_b(1'b0);
            cycle();
        end
        check("clr_hit",    {28'b0, qa}, 40'h0A0);
        cycle();
        check("clr_reload", {28'b0, qa}, 40'hAAA);

        // Hold spanning the clear edge.
        do_reset(1);
        cha_clr = 3'b111;
        for (int i = 0; i < 14; i++) begin
            rand_b(1'b0);
            cycle();
        end
        hold_a = 1'b1; da = 12'h555;
        cycle(); cycle();
        check("hold_clr",  {28'b0, qa}, 40'h0);
        for (int i = 0; i < 4; i++) cycle();
        check("hold_stay", {28'b0, qa}, 40'h0);
        hold_a = 1'b0; da = 12'hAAA;

        // Reset mid-operation restarts both counter phases.
        do_reset(1);
        for (int i = 0; i < 9; i++) begin
            rand_b(1'b0);
            cycle();
        end
        do_reset(1);
        check("midrst_q", {28'b0, qa}, 40'h0);
        for (int j = 0; j < 16; j++) begin
            check("restart_clr_a", {39'b0, clr_a}, {39'b0, (j == 15)});
            check("sweep_ce_b",    {39'b0, ce_b},  {39'b0, (j % 3 == 2)});
            check("sweep_clr_b",   {39'b0, clr_b}, {39'b0, (j % 7 == 6)});
            rand_b(1'b0);
            cycle();
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 63) != 0);
            da       = 12'($urandom());
            cha_div  = 3'($urandom());
            cha_clr  = 3'($urandom());
            hold_a   = ($urandom_range(0, 3) == 0);
            clr_en_a = 1'($urandom_range(0, 1));
            rand_b(1'b1);
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
